// File: rtl/conv_param_engine.sv
// conv_param_engine: parametrised 1-D convolution engine.
// Loads an x vector and a filter into local memories over valid/ready,
// then computes every output y[n] = sat(sum_k x[n+k]*f[k]) through one MAC
// and streams the results out with backpressure and a last-output marker.
// The stored filter can be reused for the next vector (f_keep).
module conv_param_engine #(
    parameter int WIDTH     = 10,
    parameter int OUT_WIDTH = 26,
    parameter int SIZE_X    = 112,
    parameter int SIZE_F    = 49
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     x_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [WIDTH-1:0]     f_data,
    input  logic                 f_valid,
    output logic                 f_ready,
    input  logic                 f_keep,
    output logic [OUT_WIDTH-1:0] y_data,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 y_last
);

    localparam int ACC_W = 2 * WIDTH + $clog2(SIZE_F);
    localparam int CX_W  = $clog2(SIZE_X + 1);
    localparam int CF_W  = $clog2(SIZE_F + 1);
    localparam int XA_W  = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
    localparam int FA_W  = (SIZE_F > 1) ? $clog2(SIZE_F) : 1;
    localparam int K_W   = $clog2(SIZE_F + 2);

    localparam logic [CX_W-1:0] CX_FULL = CX_W'(SIZE_X);
    localparam logic [CF_W-1:0] CF_FULL = CF_W'(SIZE_F);
    // k runs 0..SIZE_F-1 issuing reads, then two more cycles drain the pipe.
    localparam logic [K_W-1:0]  K_ISSUE = K_W'(SIZE_F);
    localparam logic [K_W-1:0]  K_DONE  = K_W'(SIZE_F + 1);
    localparam logic [XA_W-1:0] N_LAST  = XA_W'(SIZE_X - SIZE_F);

    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t                  state_q, state_d;
    logic [CX_W-1:0]         cx_q, cx_d;
    logic [CF_W-1:0]         cf_q, cf_d;
    logic [XA_W-1:0]         n_q, n_d;
    logic [K_W-1:0]          k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    x_ready_q, x_ready_d;
    logic                    f_ready_q, f_ready_d;
    logic                    y_valid_q, y_valid_d;
    logic                    y_last_q, y_last_d;
    logic [OUT_WIDTH-1:0]    y_data_q, y_data_d;
    logic                    filter_ok_q, filter_ok_d;
    logic                    skip_f_q, skip_f_d;

    logic                    x_wr, f_wr;
    logic [XA_W-1:0]         x_addr;
    logic [FA_W-1:0]         f_addr;

    logic signed [WIDTH-1:0]   x_mem [SIZE_X];
    logic signed [WIDTH-1:0]   f_mem [SIZE_F];
    logic signed [WIDTH-1:0]   rd_x_q, rd_f_q;
    logic signed [2*WIDTH-1:0] prod;

    assign x_addr = n_q + XA_W'(k_q);
    assign f_addr = FA_W'(k_q);
    assign prod   = rd_x_q * rd_f_q;

    // Clamp the full-precision sum into the signed output range.
    function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > Y_MAX) return Y_MAX[OUT_WIDTH-1:0];
        if (a < Y_MIN) return Y_MIN[OUT_WIDTH-1:0];
        return a[OUT_WIDTH-1:0];
    endfunction

    // Sample storage and the registered (1-cycle latency) MAC operand reads.
    // NOTE: the memories have no reset; every entry is written during LOAD
    // before COMPUTE reads it, so clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (x_wr) x_mem[XA_W'(cx_q)] <= x_data;
        if (f_wr) f_mem[FA_W'(cf_q)] <= f_data;
        rd_x_q <= x_mem[x_addr];
        rd_f_q <= f_mem[f_addr];
    end

    // Next-state logic: load counters, MAC sequencing, output handshake.
    // NOTE: every variable gets its default at the top of this block so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cf_d        = cf_q;
        n_d         = n_q;
        k_d         = k_q;
        acc_d       = acc_q;
        rd_vld_d    = 1'b0;
        x_ready_d   = 1'b0;
        f_ready_d   = 1'b0;
        y_valid_d   = y_valid_q;
        y_last_d    = y_last_q;
        y_data_d    = y_data_q;
        filter_ok_d = filter_ok_q;
        skip_f_d    = skip_f_q;
        x_wr        = 1'b0;
        f_wr        = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                x_wr = x_valid && x_ready_q;
                f_wr = f_valid && f_ready_q;
                if (x_wr) cx_d = cx_q + CX_W'(1);
                if (f_wr) cf_d = cf_q + CF_W'(1);
                if (f_wr && (cf_d == CF_FULL)) filter_ok_d = 1'b1;
                if ((cx_d == CX_FULL) && (skip_f_q || (cf_d == CF_FULL))) begin
                    state_d = S_COMPUTE;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end else begin
                    x_ready_d = (cx_d != CX_FULL);
                    f_ready_d = (cf_d != CF_FULL) && !skip_f_q;
                end
            end

            S_COMPUTE: begin
                rd_vld_d = (k_q < K_ISSUE);
                if (rd_vld_q) acc_d = acc_q + ACC_W'(prod);
                if (k_q == K_DONE) begin
                    state_d   = S_OUTPUT;
                    y_valid_d = 1'b1;
                    y_data_d  = sat(acc_q);
                    y_last_d  = (n_q == N_LAST);
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            S_OUTPUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    y_last_d  = 1'b0;
                    if (n_q != N_LAST) begin
                        state_d = S_COMPUTE;
                        n_d     = n_q + XA_W'(1);
                        k_d     = '0;
                        acc_d   = '0;
                    end else begin
                        state_d   = S_LOAD;
                        cx_d      = '0;
                        cf_d      = '0;
                        skip_f_d  = f_keep && filter_ok_q;
                        x_ready_d = 1'b1;
                        f_ready_d = !(f_keep && filter_ok_q);
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    // State register with synchronous active-high reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            cx_q        <= '0;
            cf_q        <= '0;
            n_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            rd_vld_q    <= 1'b0;
            x_ready_q   <= 1'b0;
            f_ready_q   <= 1'b0;
            y_valid_q   <= 1'b0;
            y_last_q    <= 1'b0;
            y_data_q    <= '0;
            filter_ok_q <= 1'b0;
            skip_f_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cf_q        <= cf_d;
            n_q         <= n_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            rd_vld_q    <= rd_vld_d;
            x_ready_q   <= x_ready_d;
            f_ready_q   <= f_ready_d;
            y_valid_q   <= y_valid_d;
            y_last_q    <= y_last_d;
            y_data_q    <= y_data_d;
            filter_ok_q <= filter_ok_d;
            skip_f_q    <= skip_f_d;
        end
    end

    assign x_ready = x_ready_q;
    assign f_ready = f_ready_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;
    assign y_data  = y_data_q;

endmodule
